// File: rtl/wb2core.sv
// Wishbone pipelined slave bridged to a req/gnt/rvalid core-interface initiator.
// Tracks granted-but-unanswered requests and drains orphaned responses after an abort.
module wb2core #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    wb_stall,
    output logic                    dev_req,
    input  logic                    dev_gnt,
    output logic [ADDR_WIDTH-1:0]   dev_addr,
    output logic                    dev_we,
    output logic [DATA_WIDTH/8-1:0] dev_be,
    output logic [DATA_WIDTH-1:0]   dev_wdata,
    input  logic                    dev_rvalid,
    input  logic [DATA_WIDTH-1:0]   dev_rdata,
    input  logic                    dev_err
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic                 req_valid_q;
    logic                 req_valid_d;
    logic [CNT_WIDTH-1:0] in_flight_q;
    logic [CNT_WIDTH-1:0] in_flight_d;
    logic                 drain_q;
    logic                 drain_d;
    logic [CNT_WIDTH:0]   occupancy;
    logic                 accept;
    logic                 grant;
    logic                 resp;
    logic                 abort;
    logic                 drain_eff;

    assign dev_req   = req_valid_q;
    assign occupancy = {1'b0, in_flight_q} + {{CNT_WIDTH{1'b0}}, req_valid_q};

    // Stalling on occupancy keeps in_flight bounded by MAX_OUTSTANDING.
    assign wb_stall = drain_q
                    | (req_valid_q & ~dev_gnt)
                    | (32'(occupancy) >= MAX_OUTSTANDING);

    assign accept = wb_cyc & wb_stb & ~wb_stall;
    assign grant  = req_valid_q & dev_gnt;
    // A response is only counted when something is (or is just becoming) outstanding.
    assign resp   = dev_rvalid & ((in_flight_q != '0) | grant);

    assign abort     = ~wb_cyc & (req_valid_q | (in_flight_q != '0));
    assign drain_eff = drain_q | abort;

    always_comb begin
        in_flight_d = in_flight_q;
        case ({grant, resp})
            2'b10:   in_flight_d = in_flight_q + CNT_WIDTH'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_WIDTH'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Accept with req_valid set implies a grant this cycle, so this covers reload.
    assign req_valid_d = accept | (req_valid_q & ~dev_gnt);
    assign drain_d     = drain_eff & (req_valid_d | (in_flight_d != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            in_flight_q <= '0;
            drain_q     <= 1'b0;
            wb_ack      <= 1'b0;
            wb_err      <= 1'b0;
            wb_dat_o    <= '0;
            dev_addr    <= '0;
            dev_we      <= 1'b0;
            dev_be      <= '0;
            dev_wdata   <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            in_flight_q <= in_flight_d;
            drain_q     <= drain_d;
            wb_ack      <= resp & ~dev_err & ~drain_eff;
            wb_err      <= resp & dev_err & ~drain_eff;
            if (resp) begin
                wb_dat_o <= dev_rdata;
            end
            if (accept) begin
                dev_addr  <= wb_adr;
                dev_we    <= wb_we;
                dev_be    <= wb_sel;
                dev_wdata <= wb_dat_i;
            end
        end
    end

    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        (dev_req && !dev_gnt) |=> (dev_req && $stable(dev_addr) && $stable(dev_we)
                                   && $stable(dev_be) && $stable(dev_wdata)));

    a_term_excl: assert property (@(posedge clk) disable iff (rst) !(wb_ack && wb_err));

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        32'(in_flight_q) <= MAX_OUTSTANDING);

endmodule

// File: tb/tb_wb2core.sv
// Directed bench for wb2core: reads, writes, pipelining, errors, abort drain and reset.
module tb_wb2core;

    logic        clk;
    logic        rst;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;
    logic        dev_req;
    logic        dev_gnt;
    logic [31:0] dev_addr;
    logic        dev_we;
    logic [3:0]  dev_be;
    logic [31:0] dev_wdata;
    logic        dev_rvalid;
    logic [31:0] dev_rdata;
    logic        dev_err;

    int checks;
    int failures;

    wb2core #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_sel    (wb_sel),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .wb_stall  (wb_stall),
        .dev_req   (dev_req),
        .dev_gnt   (dev_gnt),
        .dev_addr  (dev_addr),
        .dev_we    (dev_we),
        .dev_be    (dev_be),
        .dev_wdata (dev_wdata),
        .dev_rvalid(dev_rvalid),
        .dev_rdata (dev_rdata),
        .dev_err   (dev_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_cyc     = 1'b0;
        wb_stb     = 1'b0;
        wb_we      = 1'b0;
        wb_adr     = '0;
        wb_sel     = '0;
        wb_dat_i   = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (dev_req !== 1'b0) begin failures++; $display("FAIL reset_dev_req got=%0b exp=0", dev_req); end
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", wb_stall); end
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", wb_ack); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", wb_err); end
        checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat_o got=%h exp=0", wb_dat_o); end
        checks++; if (dev_addr !== 32'h0) begin failures++; $display("FAIL reset_dev_addr got=%h exp=0", dev_addr); end
    endtask

    task automatic test_single_read();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h100; wb_sel = 4'hf;
        dev_gnt = 1'b1;
        #1;
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL rd_stall_idle got=%0b exp=0", wb_stall); end
        step();
        wb_stb = 1'b0;
        #1;
        checks++; if (dev_req !== 1'b1) begin failures++; $display("FAIL rd_dev_req got=%0b exp=1", dev_req); end
        checks++; if (dev_addr !== 32'h100) begin failures++; $display("FAIL rd_dev_addr got=%h exp=100", dev_addr); end
        checks++; if (dev_we !== 1'b0) begin failures++; $display("FAIL rd_dev_we got=%0b exp=0", dev_we); end
        checks++; if (dev_be !== 4'hf) begin failures++; $display("FAIL rd_dev_be got=%h exp=f", dev_be); end
        step();
        checks++; if (dev_req !== 1'b0) begin failures++; $display("FAIL rd_req_drop got=%0b exp=0", dev_req); end
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%0b exp=0", wb_ack); end
        step();
        dev_rvalid = 1'b1; dev_rdata = 32'hDEADBEEF;
        step();
        dev_rvalid = 1'b0; dev_rdata = '0;
        checks++; if (wb_ack !== 1'b1) begin failures++; $display("FAIL rd_ack got=%0b exp=1", wb_ack); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%0b exp=0", wb_err); end
        checks++; if (wb_dat_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", wb_dat_o); end
        step();
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_pulse got=%0b exp=0", wb_ack); end
        idle();
        step();
    endtask

    task automatic test_write_gnt_delay();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h200; wb_sel = 4'b0011;
        wb_dat_i = 32'h1234; dev_gnt = 1'b0;
        step();
        wb_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dev_gnt = (i == 3);
            #1;
            checks++;
            if (dev_req !== 1'b1 || dev_addr !== 32'h200 || dev_be !== 4'b0011
                || dev_wdata !== 32'h1234 || dev_we !== 1'b1) begin
                failures++;
                $display("FAIL wr_hold[%0d] got req=%0b addr=%h be=%h wdata=%h we=%0b exp 1/200/3/1234/1",
                         i, dev_req, dev_addr, dev_be, dev_wdata, dev_we);
            end
            checks++;
            if (wb_stall !== (i < 3)) begin
                failures++;
                $display("FAIL wr_stall[%0d] got=%0b exp=%0b", i, wb_stall, (i < 3));
            end
            step();
        end
        dev_gnt = 1'b0;
        checks++; if (dev_req !== 1'b0) begin failures++; $display("FAIL wr_req_drop got=%0b exp=0", dev_req); end
        dev_rvalid = 1'b1;
        step();
        dev_rvalid = 1'b0;
        checks++; if (wb_ack !== 1'b1 || wb_err !== 1'b0) begin failures++; $display("FAIL wr_ack got ack=%0b err=%0b exp 1/0", wb_ack, wb_err); end
        step();
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%0b exp=0", wb_ack); end
        idle();
        step();
    endtask

    task automatic test_pipelined();
        logic [31:0] adrs [4];
        logic [31:0] exp_data [4];
        logic [31:0] q_addr [$];
        int          q_due [$];
        int          acc_cyc [4];
        int          n_acc;
        int          n_ack;
        int          outst;
        int          max_out;
        adrs     = '{32'h300, 32'h304, 32'h308, 32'h30C};
        exp_data = '{32'hCAFE0300, 32'hCAFE0304, 32'hCAFE0308, 32'hCAFE030C};
        acc_cyc  = '{-1, -1, -1, -1};
        n_acc = 0; n_ack = 0; outst = 0; max_out = 0;
        for (int k = 0; k < 24; k++) begin
            if (wb_ack) begin
                checks++;
                if (n_ack >= 4 || wb_dat_o !== exp_data[n_ack & 3]) begin
                    failures++;
                    $display("FAIL pipe_ack_data[%0d] got=%h exp=%h", n_ack, wb_dat_o, exp_data[n_ack & 3]);
                end
                n_ack++;
            end
            if (wb_err) begin
                checks++; failures++;
                $display("FAIL pipe_err cycle=%0d got=1 exp=0", k);
            end
            wb_cyc = 1'b1; wb_we = 1'b0; wb_sel = 4'hf;
            wb_stb = (n_acc < 4);
            wb_adr = (n_acc < 4) ? adrs[n_acc] : 32'h0;
            dev_gnt = 1'b1;
            if (q_due.size() > 0 && q_due[0] == k) begin
                dev_rvalid = 1'b1;
                dev_rdata  = {16'hCAFE, q_addr[0][15:0]};
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
                outst--;
            end else begin
                dev_rvalid = 1'b0;
                dev_rdata  = '0;
            end
            #1;
            if (dev_req && dev_gnt) begin
                q_addr.push_back(dev_addr);
                q_due.push_back(k + 4);
                outst++;
            end
            if (outst > max_out) max_out = outst;
            if (wb_stb && !wb_stall) begin
                acc_cyc[n_acc] = k;
                n_acc++;
            end
            step();
        end
        checks++; if (n_acc != 4) begin failures++; $display("FAIL pipe_accepts got=%0d exp=4", n_acc); end
        checks++; if (n_ack != 4) begin failures++; $display("FAIL pipe_acks got=%0d exp=4", n_ack); end
        checks++; if (max_out > 2) begin failures++; $display("FAIL pipe_outstanding got=%0d exp<=2", max_out); end
        checks++; if (acc_cyc[0] != 0 || acc_cyc[1] != 1) begin failures++; $display("FAIL pipe_b2b got=%0d,%0d exp=0,1", acc_cyc[0], acc_cyc[1]); end
        checks++; if (acc_cyc[2] != 6 || acc_cyc[3] != 7) begin failures++; $display("FAIL pipe_stall_release got=%0d,%0d exp=6,7", acc_cyc[2], acc_cyc[3]); end
        idle();
        step();
    endtask

    task automatic test_error();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h400; wb_sel = 4'hf;
        dev_gnt = 1'b1;
        step();
        wb_stb = 1'b0;
        step();
        dev_rvalid = 1'b1; dev_err = 1'b1; dev_rdata = 32'hEEEE;
        step();
        dev_rvalid = 1'b0; dev_err = 1'b0; dev_rdata = '0;
        checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%0b exp=1", wb_err); end
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL err_no_ack got=%0b exp=0", wb_ack); end
        wb_stb = 1'b1; wb_adr = 32'h404;
        step();
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL err_single got=%0b exp=0", wb_err); end
        wb_adr = 32'h408;
        #1;
        // With the errored request retired, one pending request leaves room for another.
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL err_count_dec got stall=%0b exp=0", wb_stall); end
        wb_stb = 1'b0;
        step();
        dev_rvalid = 1'b1; dev_rdata = 32'h55;
        step();
        dev_rvalid = 1'b0; dev_rdata = '0;
        checks++; if (wb_ack !== 1'b1 || wb_dat_o !== 32'h55) begin failures++; $display("FAIL err_followup got ack=%0b data=%h exp 1/55", wb_ack, wb_dat_o); end
        idle();
        step();
    endtask

    task automatic test_abort();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h500; wb_sel = 4'hf;
        dev_gnt = 1'b1;
        step();
        wb_adr = 32'h504;
        step();
        wb_stb = 1'b0;
        step();
        wb_cyc = 1'b0; dev_gnt = 1'b0;
        #1;
        checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL abort_stall_c3 got=%0b exp=1", wb_stall); end
        for (int c = 4; c <= 7; c++) begin
            step();
            dev_rvalid = (c == 5 || c == 6);
            dev_rdata  = 32'(c);
            #1;
            checks++;
            if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
                failures++;
                $display("FAIL abort_suppress c%0d got ack=%0b err=%0b exp 0/0", c, wb_ack, wb_err);
            end
            checks++;
            if (wb_stall !== (c != 7)) begin
                failures++;
                $display("FAIL abort_stall c%0d got=%0b exp=%0b", c, wb_stall, (c != 7));
            end
        end
        dev_rvalid = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h600; dev_gnt = 1'b1;
        step();
        wb_stb = 1'b0;
        checks++; if (dev_req !== 1'b1 || dev_addr !== 32'h600) begin failures++; $display("FAIL abort_new_req got req=%0b addr=%h exp 1/600", dev_req, dev_addr); end
        step();
        dev_rvalid = 1'b1; dev_rdata = 32'h00600600;
        step();
        dev_rvalid = 1'b0; dev_rdata = '0;
        checks++; if (wb_ack !== 1'b1 || wb_dat_o !== 32'h00600600) begin failures++; $display("FAIL abort_new_ack got ack=%0b data=%h exp 1/00600600", wb_ack, wb_dat_o); end
        idle();
        step();
    endtask

    task automatic test_reset_midtx();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h700; wb_sel = 4'hf;
        dev_gnt = 1'b1;
        step();
        wb_adr = 32'h704;
        step();
        wb_stb = 1'b0; dev_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (dev_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%0b exp=0", dev_req); end
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%0b exp=0", wb_stall); end
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%0b exp=0", wb_ack); end
        step();
        dev_rvalid = 1'b1; dev_rdata = 32'hBAD;
        step();
        dev_rvalid = 1'b0; dev_rdata = '0;
        checks++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin failures++; $display("FAIL rst_stray got ack=%0b err=%0b exp 0/0", wb_ack, wb_err); end
        wb_stb = 1'b1; wb_adr = 32'h800; dev_gnt = 1'b1;
        step();
        wb_stb = 1'b0;
        #1;
        // A counted stray response would leave in_flight at 1 and stall here.
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL rst_stray_count got stall=%0b exp=0", wb_stall); end
        step();
        dev_rvalid = 1'b1; dev_rdata = 32'h77;
        step();
        dev_rvalid = 1'b0; dev_rdata = '0;
        checks++; if (wb_ack !== 1'b1 || wb_dat_o !== 32'h77) begin failures++; $display("FAIL rst_followup got ack=%0b data=%h exp 1/77", wb_ack, wb_dat_o); end
        idle();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_single_read();
        test_write_gnt_delay();
        test_pipelined();
        test_error();
        test_abort();
        test_reset_midtx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
